// File: rtl/billiard_pkg.sv
// Shared constants and types for the billiard table datapath.
package billiard_pkg;

  localparam int DEFAULT_NUM_BALLS      = 4;
  localparam int DEFAULT_POCKET_SIZE    = 10;
  localparam int DEFAULT_CAPTURE_MARGIN = 2;
  localparam int CUE_BALL_IDX           = 0;
  localparam int HIT_COUNT_MAX          = 15;

  typedef enum logic {COLLECT, REPORT} hit_state_t;

  typedef logic [3:0] ball_idx_t;

endpackage

// File: rtl/pocket_window_cmp.sv
// Combinational capture-window test for one pocket: is the scan pixel inside
// the pocket sprite, inset by CAPTURE_MARGIN on every edge?
module pocket_window_cmp
  import billiard_pkg::*;
#(
  parameter int POCKET_SIZE    = DEFAULT_POCKET_SIZE,
  parameter int CAPTURE_MARGIN = DEFAULT_CAPTURE_MARGIN
) (
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               inWin
);

  localparam logic signed [11:0] LO_OFF = 12'(CAPTURE_MARGIN);
  localparam logic signed [11:0] HI_OFF = 12'(POCKET_SIZE - 1 - CAPTURE_MARGIN);

  logic signed [11:0] px, py, tlx, tly;
  logic signed [11:0] x_lo, x_hi, y_lo, y_hi;

  // Pixels are unsigned scan coordinates, the pocket may sit partly off-screen.
  assign px   = {1'b0, pixelX};
  assign py   = {1'b0, pixelY};
  assign tlx  = {topLeftX[10], topLeftX};
  assign tly  = {topLeftY[10], topLeftY};

  assign x_lo = tlx + LO_OFF;
  assign x_hi = tlx + HI_OFF;
  assign y_lo = tly + LO_OFF;
  assign y_hi = tly + HI_OFF;

  assign inWin = (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);

endmodule

// File: rtl/black_hole_hit_tracker.sv
// Collects per-frame pocket hits, then reports them one ball per clock as
// sunk/foul pulses while keeping the round's sunk mask and score.
module black_hole_hit_tracker
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS      = DEFAULT_NUM_BALLS,
  parameter int POCKET_SIZE    = DEFAULT_POCKET_SIZE,
  parameter int CAPTURE_MARGIN = DEFAULT_CAPTURE_MARGIN
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  newRound,
  input  logic           [10:0] pixelX,
  input  logic           [10:0] pixelY,
  input  logic signed    [10:0] topLeftX,
  input  logic signed    [10:0] topLeftY,
  input  logic [NUM_BALLS-1:0]  ballDR,
  output logic [NUM_BALLS-1:0]  sunkMask,
  output logic                  sunkPulse,
  output logic                  foulPulse,
  output logic            [3:0] sunkIndex,
  output logic            [3:0] hitCount,
  output logic                  allSunk
);

  localparam ball_idx_t LAST_IDX = ball_idx_t'(NUM_BALLS - 1);
  localparam ball_idx_t CUE_IDX  = ball_idx_t'(CUE_BALL_IDX);

  hit_state_t           state_q, state_d;
  ball_idx_t            scan_idx_q, scan_idx_d;
  logic [NUM_BALLS-1:0] frame_hits_q, frame_hits_d;
  logic [NUM_BALLS-1:0] snapshot_q, snapshot_d;
  logic [NUM_BALLS-1:0] sunk_mask_q, sunk_mask_d;
  logic           [3:0] hit_count_q, hit_count_d;
  ball_idx_t            sunk_index_q, sunk_index_d;
  logic                 sunk_pulse_q, sunk_pulse_d;
  logic                 foul_pulse_q, foul_pulse_d;

  logic                 in_win;
  logic [NUM_BALLS-1:0] hit_vec;
  logic                 cur_hit;

  pocket_window_cmp #(
    .POCKET_SIZE   (POCKET_SIZE),
    .CAPTURE_MARGIN(CAPTURE_MARGIN)
  ) u_window (
    .pixelX  (pixelX),
    .pixelY  (pixelY),
    .topLeftX(topLeftX),
    .topLeftY(topLeftY),
    .inWin   (in_win)
  );

  assign hit_vec = in_win ? ballDR : '0;

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    frame_hits_d = frame_hits_q | hit_vec;
    snapshot_d   = snapshot_q;
    sunk_mask_d  = sunk_mask_q;
    hit_count_d  = hit_count_q;
    sunk_index_d = sunk_index_q;
    sunk_pulse_d = 1'b0;
    foul_pulse_d = 1'b0;
    cur_hit      = 1'b0;

    for (int i = 0; i < NUM_BALLS; i++) begin
      if (scan_idx_q == ball_idx_t'(i)) cur_hit = snapshot_q[i];
    end

    if (newRound) begin
      state_d      = COLLECT;
      scan_idx_d   = '0;
      frame_hits_d = '0;
      snapshot_d   = '0;
      sunk_mask_d  = '0;
      hit_count_d  = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          // Hits seen on the frame-start cycle already belong to the new frame.
          if (startOfFrame) begin
            snapshot_d   = frame_hits_q & ~sunk_mask_q;
            frame_hits_d = hit_vec;
            scan_idx_d   = '0;
            state_d      = REPORT;
          end
        end
        REPORT: begin
          if (cur_hit) begin
            sunk_index_d = scan_idx_q;
            if (scan_idx_q == CUE_IDX) begin
              foul_pulse_d = 1'b1;
            end else begin
              sunk_pulse_d = 1'b1;
              for (int i = 1; i < NUM_BALLS; i++) begin
                if (scan_idx_q == ball_idx_t'(i)) sunk_mask_d[i] = 1'b1;
              end
              if (hit_count_q != 4'(HIT_COUNT_MAX)) hit_count_d = hit_count_q + 4'd1;
            end
          end
          if (scan_idx_q == LAST_IDX) begin
            state_d = COLLECT;
          end else begin
            scan_idx_d = scan_idx_q + 4'd1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= COLLECT;
      scan_idx_q   <= '0;
      frame_hits_q <= '0;
      snapshot_q   <= '0;
      sunk_mask_q  <= '0;
      hit_count_q  <= '0;
      sunk_index_q <= '0;
      sunk_pulse_q <= 1'b0;
      foul_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      frame_hits_q <= frame_hits_d;
      snapshot_q   <= snapshot_d;
      sunk_mask_q  <= sunk_mask_d;
      hit_count_q  <= hit_count_d;
      sunk_index_q <= sunk_index_d;
      sunk_pulse_q <= sunk_pulse_d;
      foul_pulse_q <= foul_pulse_d;
    end
  end

  assign sunkMask  = sunk_mask_q;
  assign sunkPulse = sunk_pulse_q;
  assign foulPulse = foul_pulse_q;
  assign sunkIndex = sunk_index_q;
  assign hitCount  = hit_count_q;
  assign allSunk   = &sunk_mask_q[NUM_BALLS-1:1];

endmodule

// File: doc/black_hole_hit_tracker.md
Name: black_hole_hit_tracker

Overview:
- Sits directly downstream of the pocket (black hole) position stage. Consumes the pocket's topLeftX/topLeftY, the VGA pixel scan and per-ball draw requests.
- Detects balls whose pixels fall inside the pocket's capture window during a frame. Once per frame, serializes the results into per-ball sunk/foul pulses.
- Keeps the round's sunk mask and score count for the game controller and the score display.

Parameters:
- NUM_BALLS, 4, number of balls. Index 0 is the cue ball. Legal range is 2..16.
- POCKET_SIZE, 10, pocket sprite width and height in pixels.
- CAPTURE_MARGIN, 2, inset in pixels from each pocket edge that defines the capture window.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-clock pulse at frame start (30Hz)
- newRound  in  1  one-clock pulse that clears round state
- pixelX  in  11  current scan X, unsigned
- pixelY  in  11  current scan Y, unsigned
- topLeftX  in  11 signed  pocket top-left X
- topLeftY  in  11 signed  pocket top-left Y
- ballDR  in  NUM_BALLS  per-ball draw request for the current pixel
- sunkMask  out  NUM_BALLS  balls sunk this round. Bit 0 is always 0.
- sunkPulse  out  1  one-clock pulse: ball sunkIndex was sunk
- foulPulse  out  1  one-clock pulse: the cue ball entered the pocket
- sunkIndex  out  4  index qualifying sunkPulse/foulPulse. Holds its last value otherwise.
- hitCount  out  4  number of object balls sunk, saturating at 15
- allSunk  out  1  high when sunkMask[NUM_BALLS-1:1] is all ones

Behaviour:
- Reset: every output is 0, frameHits=0, snapshot=0, state=COLLECT, scanIdx=0.
- Capture window: inWin is combinational.
  - Condition: pixelX in [topLeftX+CAPTURE_MARGIN, topLeftX+POCKET_SIZE-1-CAPTURE_MARGIN], and the same rule for Y.
  - All compares are done sign-extended to 12 bits. pixelX/Y are zero-extended, so a negative topLeft never wraps.
  - With the defaults and topLeft=(16,16), the window is X 18..23, Y 18..23.
- Accumulation: every clock, frameHits <= frameHits | (inWin ? ballDR : 0). This runs in all states.
- COLLECT state, on startOfFrame:
  - snapshot <= frameHits & ~sunkMask. Cue ball bit 0 is never masked.
  - frameHits <= (inWin ? ballDR : 0), so hits on the startOfFrame cycle belong to the new frame.
  - scanIdx <= 0; state moves to REPORT.
- REPORT state: one index per clock, scanIdx from 0 to NUM_BALLS-1.
  - For scanIdx=i with snapshot[i]=1, the outputs are registered on the next edge:
    - i=0: foulPulse=1, sunkIndex=0. sunkMask and hitCount are unchanged; the cue ball respawns.
    - i≥1: sunkPulse=1, sunkIndex=i, sunkMask[i]<=1, hitCount<=min(hitCount+1,15).
  - After index NUM_BALLS-1, state returns to COLLECT.
  - At most one pulse per clock. Pulses are never asserted outside REPORT+1 cycles.
- Latency: a pulse for ball i is high exactly on clock startOfFrame+2+i, counting the startOfFrame cycle as 0.
- Once per round: a ball already in sunkMask never pulses again until newRound.
- startOfFrame while in REPORT: ignored. No new snapshot is taken, and frameHits keeps accumulating for the next COLLECT startOfFrame.
- newRound has priority over everything except reset. In the same edge it does all of the following:
  - clears sunkMask, hitCount, frameHits and snapshot;
  - sets state=COLLECT;
  - deasserts both pulses. A REPORT in progress is aborted.
- newRound together with startOfFrame: newRound wins; no snapshot is taken.
- allSunk is combinational from sunkMask; it is registered-stable because sunkMask is a register.

Decomposition:
- billiard_pkg holds:
  - NUM_BALLS, POCKET_SIZE, CAPTURE_MARGIN defaults;
  - CUE_BALL_IDX=0;
  - typedef enum logic {COLLECT, REPORT} hit_state_t;
  - typedef logic [3:0] ball_idx_t.
- One sub-module, pocket_window_cmp: combinational signed window compare (pixelX/Y, topLeftX/Y → inWin). It is reused later for the other pockets.

Test Plan:
- Reset: hold resetN=0 with ballDR=4'b1111 in the window → all outputs 0 and no pulses until the first post-reset startOfFrame.
- Single sink: topLeft=(16,16), ballDR[2]=1 at pixel (20,20) for 1 cycle, then startOfFrame → sunkPulse with sunkIndex=2 on cycle +4; sunkMask=4'b0100; hitCount=1.
- Window edges: ballDR[1] only at (17,20) and (24,20) → no pulse. At (18,18) and at (23,23) → pulse.
- Cue foul and repeat: ballDR[0] in window for two frames → foulPulse with sunkIndex=0 each frame; sunkMask stays 0; hitCount stays 0.
- Multi-ball and allSunk: ballDR=4'b1110 in window in one frame → three sunkPulses on consecutive cycles with sunkIndex 1,2,3; hitCount=3; allSunk=1. The same hits in the next frame → no pulses.
- newRound mid-REPORT: assert newRound on the cycle after startOfFrame with snapshot 4'b1110 → no further pulses; sunkMask=0; hitCount=0; a later frame re-detects ball 1.
